// File: rtl/instr_meter_pkg.sv
// Shared types and defaults for the instrumented adder ring-oscillator meter.
package instr_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } meter_state_t;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_WIN_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int MIN_SYNC_STAGES = 2;

    // Depths below the metastability minimum are raised to it.
    function automatic int sync_depth(input int requested);
        int depth;
        if (requested < MIN_SYNC_STAGES) begin
            depth = MIN_SYNC_STAGES;
        end else begin
            depth = requested;
        end
        return depth;
    endfunction

endpackage

// File: rtl/instr_meter_sync.sv
// Synchroniser for the asynchronous ring output plus rising-edge detect.
// These flops are the only logic that sees osc_in directly.
module instr_meter_sync #(
    parameter int STAGES = 2
) (
    input  logic wb_clk_i,
    input  logic wb_rst_n,
    input  logic osc_in,
    output logic osc_rise
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchroniser chain and previous-sample register, updated every cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], osc_in};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign osc_rise = sync_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/instrumented_adder_meter.sv
// Ring-oscillator gate-window edge counter for the instrumented adder.
// Optional INSTR_METER_CONTINUOUS_EN adds a `continuous` input for back-to-back windows.
module instrumented_adder_meter
    import instr_meter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WIN_W       = DEF_WIN_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n,
    input  logic                     active,
    input  logic                     start,
    input  logic [WIN_W-1:0]         window,
    input  logic [$clog2(WIDTH)-1:0] tap_sel,
    input  logic                     osc_in,
`ifdef INSTR_METER_CONTINUOUS_EN
    input  logic                     continuous,
`endif
    output logic [WIDTH-1:0]         ring_en_b,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         count,
    output logic                     overflow
);

    localparam int TAP_W  = $clog2(WIDTH);
    localparam int SYNC_N = sync_depth(SYNC_STAGES);
    localparam int TMR_W  = (WIN_W > 8) ? WIN_W : 8;

    meter_state_t       state_r;
    logic [WIN_W-1:0]   win_r;
    logic [TAP_W-1:0]   tap_r;
    logic [TMR_W-1:0]   tmr_r;
    logic [WIDTH-1:0]   ring_en_b_r;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   count_r;
    logic               overflow_r;
    logic               osc_rise_s;
    logic               cont_s;

`ifdef INSTR_METER_CONTINUOUS_EN
    assign cont_s = continuous;
`else
    assign cont_s = 1'b0;
`endif

    // Out-of-range taps leave every enable deasserted, so the ring never runs.
    function automatic logic [WIDTH-1:0] tap_mask_b(input logic [TAP_W-1:0] t);
        logic [WIDTH-1:0] m;
        m = {WIDTH{1'b1}};
        if (32'(t) < WIDTH) begin
            m[t] = 1'b0;
        end else begin
            m = {WIDTH{1'b1}};
        end
        return m;
    endfunction

    instr_meter_sync #(
        .STAGES   (SYNC_N)
    ) u_sync (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .osc_in   (osc_in),
        .osc_rise (osc_rise_s)
    );

    // Measurement FSM with registered ring enables, status and result.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_r     <= ST_IDLE;
            win_r       <= {WIN_W{1'b0}};
            tap_r       <= {TAP_W{1'b0}};
            tmr_r       <= {TMR_W{1'b0}};
            ring_en_b_r <= {WIDTH{1'b1}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
        end else if (!active) begin
            // Abort keeps the partial count and overflow for inspection.
            state_r     <= ST_IDLE;
            ring_en_b_r <= {WIDTH{1'b1}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        win_r       <= window;
                        tap_r       <= tap_sel;
                        tmr_r       <= TMR_W'(SYNC_N);
                        ring_en_b_r <= tap_mask_b(tap_sel);
                        busy_r      <= 1'b1;
                        count_r     <= {CNT_W{1'b0}};
                        overflow_r  <= 1'b0;
                        state_r     <= ST_SETTLE;
                    end else begin
                        busy_r      <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_r != {TMR_W{1'b0}}) begin
                        tmr_r <= tmr_r - TMR_W'(1);
                    end else if (win_r == {WIN_W{1'b0}}) begin
                        ring_en_b_r <= {WIDTH{1'b1}};
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        tmr_r   <= TMR_W'(win_r) - TMR_W'(1);
                        state_r <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (osc_rise_s) begin
                        if (count_r != {CNT_W{1'b1}}) begin
                            count_r <= count_r + CNT_W'(1);
                        end else begin
                            overflow_r <= 1'b1;
                        end
                    end
                    if (tmr_r != {TMR_W{1'b0}}) begin
                        tmr_r <= tmr_r - TMR_W'(1);
                    end else begin
                        ring_en_b_r <= {WIDTH{1'b1}};
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (cont_s) begin
                        tmr_r       <= TMR_W'(SYNC_N);
                        ring_en_b_r <= tap_mask_b(tap_r);
                        count_r     <= {CNT_W{1'b0}};
                        overflow_r  <= 1'b0;
                        state_r     <= ST_SETTLE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    ring_en_b_r <= {WIDTH{1'b1}};
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ring_en_b = ring_en_b_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign count     = count_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_instrumented_adder_meter.sv
// Scoreboard bench: a ring model per DUT toggles only while a tap is enabled.
module tb_instrumented_adder_meter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, active, start_a, start_b, continuous;
    logic [15:0] window;
    logic [4:0]  tap_a, tap_b;
    logic        osc_a = 1'b0, osc_b = 1'b0;
    logic [31:0] ring_a;
    logic [23:0] ring_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic [31:0] count_a;
    logic [3:0]  count_b;

    int half_p = 3;
    int ph_a = 0, ph_b = 0;
    int cyc = 0;
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
        int          cyc;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    instrumented_adder_meter dut_a (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .active     (active),
        .start      (start_a),
        .window     (window),
        .tap_sel    (tap_a),
        .osc_in     (osc_a),
`ifdef INSTR_METER_CONTINUOUS_EN
        .continuous (continuous),
`endif
        .ring_en_b  (ring_a),
        .busy       (busy_a),
        .done       (done_a),
        .count      (count_a),
        .overflow   (ovf_a)
    );

    instrumented_adder_meter #(.WIDTH(24), .CNT_W(4)) dut_b (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .active     (active),
        .start      (start_b),
        .window     (window),
        .tap_sel    (tap_b),
        .osc_in     (osc_b),
`ifdef INSTR_METER_CONTINUOUS_EN
        .continuous (1'b0),
`endif
        .ring_en_b  (ring_b),
        .busy       (busy_b),
        .done       (done_b),
        .count      (count_b),
        .overflow   (ovf_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Ring models: square wave of half-period half_p, held low while disabled.
    always @(negedge clk) begin
        if (ring_a != 32'hFFFF_FFFF) begin
            if (ph_a >= half_p - 1) begin ph_a = 0; osc_a = ~osc_a; end
            else ph_a = ph_a + 1;
        end else begin
            ph_a = 0; osc_a = 1'b0;
        end
        if (ring_b != 24'hFF_FFFF) begin
            if (ph_b >= half_p - 1) begin ph_b = 0; osc_b = ~osc_b; end
            else ph_b = ph_b + 1;
        end else begin
            ph_b = 0; osc_b = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && done_a) begin
            if (q_a.size() == 0) begin
                check_eq("unexpected_done_a", 64'(done_a), 64'd0);
            end else begin
                e = q_a.pop_front();
                check_eq("count_a", 64'(count_a), 64'(e.cnt));
                check_eq("ovf_a", 64'(ovf_a), 64'(e.ovf));
                check_eq("done_cycle_a", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && done_b) begin
            if (q_b.size() == 0) begin
                check_eq("unexpected_done_b", 64'(done_b), 64'd0);
            end else begin
                e = q_b.pop_front();
                check_eq("count_b", 64'(count_b), 64'(e.cnt));
                check_eq("ovf_b", 64'(ovf_b), 64'(e.ovf));
                check_eq("done_cycle_b", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Start accepted at the edge after this negedge; done seen SYNC+1+window edges later.
    task automatic start_run_a(input logic [15:0] win, input logic [4:0] tap,
                               input logic [31:0] exp_cnt, input logic exp_ovf, input int n_done);
        @(negedge clk);
        window = win; tap_a = tap; start_a = 1'b1;
        for (int k = 0; k < n_done; k++)
            q_a.push_back('{exp_cnt, exp_ovf, cyc + 4 + int'(win) + k * (int'(win) + 4)});
        @(negedge clk);
        start_a = 1'b0;
        check_eq("busy_after_start_a", 64'(busy_a), 64'd1);
    endtask

    task automatic start_run_b(input logic [15:0] win, input logic [4:0] tap,
                               input logic [31:0] exp_cnt, input logic exp_ovf);
        @(negedge clk);
        window = win; tap_b = tap; start_b = 1'b1;
        q_b.push_back('{exp_cnt, exp_ovf, cyc + 4 + int'(win)});
        @(negedge clk);
        start_b = 1'b0;
        check_eq("busy_after_start_b", 64'(busy_b), 64'd1);
    endtask

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b) && t < limit) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_in_time", 64'(t < limit), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; active = 1'b0; start_a = 1'b0; start_b = 1'b0;
        continuous = 1'b0; window = 16'd0; tap_a = 5'd0; tap_b = 5'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_ring_a", 64'(ring_a), 64'hFFFF_FFFF);
        check_eq("rst_ring_b", 64'(ring_b), 64'hFF_FFFF);
        check_eq("rst_busy", 64'(busy_a), 64'd0);
        check_eq("rst_count", 64'(count_a), 64'd0);
        check_eq("rst_done_ovf", 64'({done_a, ovf_a}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Start while inactive must be ignored.
        start_a = 1'b1; window = 16'd10; tap_a = 5'd1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("inactive_busy", 64'(busy_a), 64'd0);
        check_eq("inactive_ring", 64'(ring_a), 64'hFFFF_FFFF);
        active = 1'b1;

        // Basic count: period 6, window 60, tap 10.
        half_p = 3;
        start_run_a(16'd60, 5'd10, 32'd10, 1'b0, 1);
        @(negedge clk);
        check_eq("ring_settle_a", 64'(ring_a), 64'hFFFF_FBFF);
        repeat (20) @(negedge clk);
        check_eq("ring_count_a", 64'(ring_a), 64'hFFFF_FBFF);
        // Second start while busy: must not yield a second done.
        start_a = 1'b1; tap_a = 5'd2;
        @(negedge clk);
        start_a = 1'b0;
        wait_drain(300);
        check_eq("ring_idle_a", 64'(ring_a), 64'hFFFF_FFFF);

        // Zero window skips counting.
        start_run_a(16'd0, 5'd7, 32'd0, 1'b0, 1);
        wait_drain(50);

        // Out-of-range tap on the 24-wide meter.
        start_run_b(16'd60, 5'd28, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("ring_bad_tap_b", 64'(ring_b), 64'hFF_FFFF);
        wait_drain(300);

        // Saturation at 4 bits, then the next start clears.
        half_p = 1;
        start_run_b(16'd100, 5'd3, 32'd15, 1'b1);
        wait_drain(300);
        start_run_b(16'd0, 5'd3, 32'd0, 1'b0);
        @(negedge clk);
        check_eq("sat_cleared_count_b", 64'(count_b), 64'd0);
        wait_drain(50);

        // Abort 5 cycles into COUNT: no done, ring released.
        half_p = 3;
        start_run_a(16'd60, 5'd4, 32'd0, 1'b0, 0);
        repeat (7) @(negedge clk);
        active = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 64'(busy_a), 64'd0);
        check_eq("abort_ring", 64'(ring_a), 64'hFFFF_FFFF);
        check_eq("abort_done", 64'(done_a), 64'd0);
        repeat (80) @(negedge clk);
        active = 1'b1;

`ifdef INSTR_METER_CONTINUOUS_EN
        // Continuous: window 12, period 4, three windows then stop.
        half_p = 2;
        continuous = 1'b1;
        start_run_a(16'd12, 5'd5, 32'd3, 1'b0, 3);
        begin
            int t;
            t = 0;
            while (q_a.size() > 1 && t < 200) begin @(negedge clk); t++; end
            check_eq("cont_second_done", 64'(t < 200), 64'd1);
        end
        repeat (4) @(negedge clk);
        continuous = 1'b0;
        wait_drain(100);
        repeat (20) @(negedge clk);
        check_eq("cont_stopped_busy", 64'(busy_a), 64'd0);
`endif

        wait_drain(100);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
